// File: rtl/psel_gen_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | psel_gen_unit: up to REQS one-hot grants, lowest request index first  |
// | rev 1.0                                                               |
// +----------------------------------------------------------------------+
module psel_gen_unit #(
  parameter int WIDTH = 8,
  parameter int REQS  = 2
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [WIDTH-1:0]             req,
  output logic [REQS-1:0][WIDTH-1:0]   gnt_bus,
  output logic [WIDTH-1:0]             gnt,
  output logic                         empty,
  output logic [REQS-1:0][WIDTH-1:0]   gnt_bus_q
);

  localparam logic [WIDTH-1:0] c_one = WIDTH'(1);

  logic [REQS-1:0][WIDTH-1:0] sel_bus;
  logic [REQS-1:0][WIDTH-1:0] gnt_bus_d;
  logic [WIDTH-1:0]           remaining;
  logic [WIDTH-1:0]           gnt_or;

  // Each stage takes the lowest bit still available (x & -x), then masks it off
  // so later stages move up the index order and never reuse a bit.
  always_comb begin
    remaining = req;
    sel_bus   = '0;
    gnt_or    = '0;
    for (int k = 0; k < REQS; k++) begin
      sel_bus[k] = remaining & (~remaining + c_one);
      remaining  = remaining & ~sel_bus[k];
      gnt_or     = gnt_or | sel_bus[k];
    end
  end

  assign gnt_bus = sel_bus;
  assign gnt     = gnt_or;
  assign empty   = ~|req;

  always_comb begin
    gnt_bus_d = sel_bus;
    if (reset) begin
      gnt_bus_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    gnt_bus_q <= gnt_bus_d;
  end

endmodule
`default_nettype wire

// File: tb/tb_psel_gen_unit.sv
`default_nettype none
// Bench for psel_gen_unit: directed cases, exhaustive sweep over REQS=1..8,
// randomized registered-path checks against a bit-scanning reference model.
module tb_psel_gen_unit;

  logic       clock;
  logic       reset;
  logic [7:0] req;
  logic [3:0] req4;
  logic       req1;

  int n_checks;
  int n_fail;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Main instance, WIDTH=8 REQS=2
  logic [1:0][7:0] gnt_bus, gnt_bus_q;
  logic [7:0]      gnt;
  logic            empty;

  psel_gen_unit #(.WIDTH(8), .REQS(2)) u_dut (
    .clock(clock), .reset(reset), .req(req),
    .gnt_bus(gnt_bus), .gnt(gnt), .empty(empty), .gnt_bus_q(gnt_bus_q)
  );

  // WIDTH=4 REQS=4
  logic [3:0][3:0] w4_bus, w4_q;
  logic [3:0]      w4_gnt;
  logic            w4_empty;

  psel_gen_unit #(.WIDTH(4), .REQS(4)) u_w4 (
    .clock(clock), .reset(reset), .req(req4),
    .gnt_bus(w4_bus), .gnt(w4_gnt), .empty(w4_empty), .gnt_bus_q(w4_q)
  );

  // WIDTH=1 REQS=1
  logic [0:0][0:0] w1_bus, w1_q;
  logic            w1_gnt;
  logic            w1_empty;

  psel_gen_unit #(.WIDTH(1), .REQS(1)) u_w1 (
    .clock(clock), .reset(reset), .req(req1),
    .gnt_bus(w1_bus), .gnt(w1_gnt), .empty(w1_empty), .gnt_bus_q(w1_q)
  );

  // WIDTH=8 with every REQS from 1 to 8, outputs zero-extended to 64 bits
  wire [63:0] sw_bus   [1:8];
  wire [63:0] sw_q     [1:8];
  wire [7:0]  sw_gnt   [1:8];
  wire        sw_empty [1:8];

  for (genvar r = 1; r <= 8; r++) begin : g_sweep
    logic [r-1:0][7:0] bus, q;
    logic [7:0]        g;
    logic              e;
    psel_gen_unit #(.WIDTH(8), .REQS(r)) u_sw (
      .clock(clock), .reset(reset), .req(req),
      .gnt_bus(bus), .gnt(g), .empty(e), .gnt_bus_q(q)
    );
    assign sw_bus[r]   = 64'(bus);
    assign sw_q[r]     = 64'(q);
    assign sw_gnt[r]   = g;
    assign sw_empty[r] = e;
  end

  // Reference: scan request bits upward, handing out slots until n are used.
  function automatic logic [63:0] model_bus(input logic [7:0] r, input int n);
    logic [63:0] res;
    int          cnt;
    res = '0;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (r[i] && cnt < n) begin
        res[cnt*8 +: 8] = 8'(1 << i);
        cnt++;
      end
    end
    return res;
  endfunction

  function automatic logic [7:0] model_gnt(input logic [7:0] r, input int n);
    logic [63:0] b;
    logic [7:0]  g;
    b = model_bus(r, n);
    g = '0;
    for (int k = 0; k < 8; k++) g = g | b[k*8 +: 8];
    return g;
  endfunction

  task automatic test_reset();
    @(negedge clock);
    reset = 1'b1;
    req   = 8'h00;
    @(posedge clock); #1;
    n_checks++;
    if (gnt_bus_q !== 16'h0000) begin
      n_fail++; $display("FAIL reset_q: got %h expected 0000", gnt_bus_q);
    end
    n_checks++;
    if ({gnt_bus, gnt, empty} !== {16'h0000, 8'h00, 1'b1}) begin
      n_fail++; $display("FAIL reset_comb: got %h/%h/%b expected 0000/00/1", gnt_bus, gnt, empty);
    end
  endtask

  task automatic test_directed();
    logic [7:0]  vecs [3];
    logic [15:0] exp_bus [3];
    logic [7:0]  exp_gnt [3];
    vecs[0] = 8'b0000_0000; exp_bus[0] = 16'h0000; exp_gnt[0] = 8'h00;
    vecs[1] = 8'b1011_0100; exp_bus[1] = 16'h1004; exp_gnt[1] = 8'h14;
    vecs[2] = 8'b1000_0000; exp_bus[2] = 16'h0080; exp_gnt[2] = 8'h80;
    for (int i = 0; i < 3; i++) begin
      req = vecs[i];
      #1;
      n_checks++;
      if (gnt_bus !== exp_bus[i] || gnt !== exp_gnt[i] || empty !== (vecs[i] == 8'h00)) begin
        n_fail++;
        $display("FAIL directed_%0d: req=%b got bus=%h gnt=%h empty=%b expected bus=%h gnt=%h empty=%b",
                 i, vecs[i], gnt_bus, gnt, empty, exp_bus[i], exp_gnt[i], vecs[i] == 8'h00);
      end
    end
  endtask

  task automatic test_narrow();
    req4 = 4'b1111;
    req1 = 1'b0;
    #1;
    n_checks++;
    if (w4_bus !== 16'h8421 || w4_gnt !== 4'hf || w4_empty !== 1'b0) begin
      n_fail++; $display("FAIL w4_all_ones: got %h/%h/%b expected 8421/f/0", w4_bus, w4_gnt, w4_empty);
    end
    n_checks++;
    if (w1_bus !== 1'b0 || w1_gnt !== 1'b0 || w1_empty !== 1'b1) begin
      n_fail++; $display("FAIL w1_zero: got %b/%b/%b expected 0/0/1", w1_bus, w1_gnt, w1_empty);
    end
    req4 = 4'b1010;
    req1 = 1'b1;
    #1;
    n_checks++;
    if (w4_bus !== 16'h0082 || w4_gnt !== 4'ha || w4_empty !== 1'b0) begin
      n_fail++; $display("FAIL w4_partial: got %h/%h/%b expected 0082/a/0", w4_bus, w4_gnt, w4_empty);
    end
    n_checks++;
    if (w1_bus !== 1'b1 || w1_gnt !== 1'b1 || w1_empty !== 1'b0) begin
      n_fail++; $display("FAIL w1_one: got %b/%b/%b expected 1/1/0", w1_bus, w1_gnt, w1_empty);
    end
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;
    n_checks++;
    if (w4_q !== 16'h0082 || w1_q !== 1'b1) begin
      n_fail++; $display("FAIL narrow_q: got %h/%b expected 0082/1", w4_q, w1_q);
    end
  endtask

  task automatic test_sweep();
    for (int v = 0; v < 256; v++) begin
      req = 8'(v);
      #1;
      for (int r = 1; r <= 8; r++) begin
        n_checks++;
        if (sw_bus[r] !== model_bus(req, r) || sw_gnt[r] !== model_gnt(req, r) ||
            sw_empty[r] !== (req == 8'h00)) begin
          n_fail++;
          $display("FAIL sweep req=%h reqs=%0d: got bus=%h gnt=%h empty=%b expected bus=%h gnt=%h",
                   req, r, sw_bus[r], sw_gnt[r], sw_empty[r], model_bus(req, r), model_gnt(req, r));
        end
      end
    end
  endtask

  task automatic test_registered();
    @(negedge clock);
    req   = 8'b0000_0110;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    n_checks++;
    if (gnt_bus_q !== 16'h0000) begin
      n_fail++; $display("FAIL reg_hold_reset: got %h expected 0000", gnt_bus_q);
    end
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;
    n_checks++;
    if (gnt_bus_q !== 16'h0402) begin
      n_fail++; $display("FAIL reg_load: got %h expected 0402", gnt_bus_q);
    end
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;
    n_checks++;
    if (gnt_bus_q !== 16'h0000 || gnt_bus !== 16'h0402) begin
      n_fail++; $display("FAIL reg_reassert: got q=%h bus=%h expected q=0000 bus=0402", gnt_bus_q, gnt_bus);
    end
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;
    n_checks++;
    if (gnt_bus_q !== 16'h0402) begin
      n_fail++; $display("FAIL reg_resume: got %h expected 0402", gnt_bus_q);
    end
  endtask

  task automatic test_random();
    logic [7:0] r_req;
    logic       r_rst;
    for (int it = 0; it < 60; it++) begin
      @(negedge clock);
      r_req = 8'($urandom);
      r_rst = ($urandom_range(0, 7) == 0);
      req   = r_req;
      reset = r_rst;
      @(posedge clock); #1;
      for (int r = 1; r <= 8; r++) begin
        n_checks++;
        if (sw_q[r] !== (r_rst ? 64'h0 : model_bus(r_req, r))) begin
          n_fail++;
          $display("FAIL random_q req=%h reset=%b reqs=%0d: got %h expected %h",
                   r_req, r_rst, r, sw_q[r], r_rst ? 64'h0 : model_bus(r_req, r));
        end
      end
      n_checks++;
      if (64'(gnt_bus) !== model_bus(r_req, 2)) begin
        n_fail++; $display("FAIL random_comb req=%h: got %h expected %h", r_req, gnt_bus, model_bus(r_req, 2));
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    req      = 8'h00;
    req4     = 4'h0;
    req1     = 1'b0;
    test_reset();
    test_directed();
    test_narrow();
    test_sweep();
    test_registered();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
